program_loader: RTL and testbench
=================================

# program_loader

Serial program loader for the accumulator core's instruction-memory write port. It receives an 8N1 UART byte stream on one pin and parses a framed program image. It drives the core's load interface (write enable, 5-bit address, 8-bit data) with one write per payload byte. It holds the core in reset while loading and reports completion or error, so a host can download a program over a single wire instead of driving the parallel load pins.

## Interface
- CLKS_PER_BIT, default 104: clock cycles per UART bit; legal range 4..65535.
- MEM_DEPTH, default 27: number of instruction-memory locations; maximum legal frame length.
- SYNC_BYTE, default 8'h55: frame start marker.

- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous UART receive line; idle high.
- load_we  output  1  one-cycle write strobe to the core's instruction memory.
- load_addr  output  5  write address; valid when load_we=1.
- load_data  output  8  write data; valid when load_we=1.
- cpu_hold  output  1  high while a frame is in progress; the core must be held in reset.
- busy  output  1  high when the frame parser is in any state other than HUNT.
- done  output  1  one-cycle pulse when a frame completes successfully.
- err  output  1  sticky error flag; cleared when the next SYNC_BYTE is accepted.

## Operation
- rxd passes through a 2-flop synchronizer before any use.
- Byte receiver states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized falling edge.
  - START: after CLKS_PER_BIT/2 cycles, rxd low -> DATA; rxd high -> IDLE (glitch, no byte).
  - DATA: samples 8 bits LSB-first, one every CLKS_PER_BIT cycles.
  - STOP: samples 1 bit. Stop=1 -> byte_valid pulse, then IDLE. Stop=0 -> framing error (err<=1, frame aborted to HUNT), then IDLE.
- Frame parser states: HUNT, LEN, PAYLOAD, CHK.
  - HUNT: bytes other than SYNC_BYTE are ignored. SYNC_BYTE -> LEN; clears err; asserts cpu_hold.
  - LEN: length N is accepted if 1..MEM_DEPTH. Accepted N -> PAYLOAD, address counter=0. N=0 or N>MEM_DEPTH -> err<=1, HUNT, no writes.
  - PAYLOAD: each byte produces one write at the current address; the address then increments. After the Nth byte -> CHK (or finish; see Configuration).
  - CHK: pass if the 8-bit sum of the N payload bytes plus the checksum byte equals 8'h00 (modulo 256) -> done pulse. Fail -> err<=1. Either outcome returns to HUNT.
- Writes already issued are not rolled back on error. err tells the host to resend.
- cpu_hold deasserts in the same cycle the parser returns to HUNT, for success or error.

## Timing
- Reset values: load_we=0, load_addr=0, load_data=0, cpu_hold=0, busy=0, done=0, err=0. Both FSMs go to IDLE/HUNT and all counters clear.
- rst mid-byte or mid-frame aborts immediately. No write or done is issued for a partial frame.
- byte_valid is asserted 1 cycle after the stop-bit sample. load_we is asserted in the cycle after byte_valid. load_addr and load_data are registered and stable during that cycle.
- done is asserted in the cycle after the checksum byte's byte_valid. cpu_hold falls in that same cycle.
- Minimum frame byte spacing is one stop bit. The receiver accepts back-to-back bytes with no idle gap.
- The address counter is 5 bits and never exceeds N-1 ≤ MEM_DEPTH-1, so it does not wrap.
- A framing error during PAYLOAD or CHK aborts the frame: err=1, HUNT, cpu_hold falls 1 cycle after the stop sample.

## Configuration
- LOADER_CHECKSUM_EN defined: the frame is SYNC, LEN, N payload bytes, CHK, and the checksum is verified as above.
- LOADER_CHECKSUM_EN undefined: there is no CHK state or byte. done pulses in the cycle after the Nth payload write, and the parser returns to HUNT. Checksum failure cannot occur.

## Test plan
- With checksum enabled, send 55 03 01 05 02 F8 -> writes (0,01), (1,05), (2,02); one done pulse; err=0; cpu_hold high from SYNC acceptance to done.
- Send 55 02 01 05 00 (bad checksum) -> writes (0,01), (1,05); no done; err=1. Then send 55 -> err clears.
- Send 55 00, then separately 55 1C (length 28) -> no writes, err=1, parser back in HUNT.
- Send AA 13 55 01 0A F6 -> AA and 13 are ignored; one write (0,0A); done pulse.
- Drive a 0.25-bit low glitch on idle rxd -> no byte received, no state change. Separately, drive a stop bit of 0 during PAYLOAD -> err=1, HUNT, no further writes.
- Assert rst after the 2nd payload byte of a 5-byte frame -> all outputs 0 next cycle; a following complete frame loads correctly starting from address 0.

Source files
------------

// File: rtl/program_loader.sv
// UART-fed program loader: parses SYNC, LEN, payload[, CHK] frames into instruction-memory writes.
// Define LOADER_CHECKSUM_EN to add the trailing checksum byte and its verification.
module program_loader #(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned MEM_DEPTH    = 27,
   parameter logic [7:0]  SYNC_BYTE    = 8'h55
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic       load_we,
   output logic [4:0] load_addr,
   output logic [7:0] load_data,
   output logic       cpu_hold,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [7:0]  DEPTH_MAX = 8'(MEM_DEPTH);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [1:0] {P_HUNT, P_LEN, P_PAYLOAD, P_CHK} p_state_t;
`else
   typedef enum logic [1:0] {P_HUNT, P_LEN, P_PAYLOAD} p_state_t;
`endif

   logic        rx_meta, rx_sync, rx_prev;
   rx_state_t   rx_state;
   logic [15:0] bit_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        byte_valid;
   logic        stop_fail;

   p_state_t    p_state;
   logic [4:0]  addr_cnt;
   logic [4:0]  last_addr;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  sum;
   logic [7:0]  chk_sum;
   assign chk_sum = sum + shift;
`else
   logic        finish_pending;
`endif

   // Framing error is seen by the parser in the sample cycle itself so cpu_hold drops one cycle later.
   assign stop_fail = (rx_state == RX_STOP) && (bit_cnt == BIT_LAST) && !rx_sync;
   assign cpu_hold  = (p_state != P_HUNT);
   assign busy      = (p_state != P_HUNT);

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         rx_prev    <= 1'b1;
         rx_state   <= RX_IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
      end else begin
         rx_meta    <= rxd;
         rx_sync    <= rx_meta;
         rx_prev    <= rx_sync;
         byte_valid <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               bit_cnt <= '0;
               if (rx_prev && !rx_sync) rx_state <= RX_START;
            end
            RX_START: begin
               if (bit_cnt == HALF_LAST) begin
                  bit_cnt  <= '0;
                  bit_idx  <= '0;
                  rx_state <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  bit_cnt <= bit_cnt + 16'd1;
               end
            end
            RX_DATA: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  shift   <= {rx_sync, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) rx_state <= RX_STOP;
               end else begin
                  bit_cnt <= bit_cnt + 16'd1;
               end
            end
            RX_STOP: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt    <= '0;
                  byte_valid <= rx_sync;
                  rx_state   <= RX_IDLE;
               end else begin
                  bit_cnt <= bit_cnt + 16'd1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_state        <= P_HUNT;
         addr_cnt       <= '0;
         last_addr      <= '0;
         load_we        <= 1'b0;
         load_addr      <= '0;
         load_data      <= '0;
         done           <= 1'b0;
         err            <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum            <= '0;
`else
         finish_pending <= 1'b0;
`endif
      end else begin
         load_we <= 1'b0;
         done    <= 1'b0;
         if (stop_fail) begin
            err     <= 1'b1;
            p_state <= P_HUNT;
`ifndef LOADER_CHECKSUM_EN
            finish_pending <= 1'b0;
`endif
         end else if (byte_valid) begin
            case (p_state)
               P_HUNT: begin
                  if (shift == SYNC_BYTE) begin
                     p_state <= P_LEN;
                     err     <= 1'b0;
                  end
               end
               P_LEN: begin
                  if (shift != 8'd0 && shift <= DEPTH_MAX) begin
                     p_state   <= P_PAYLOAD;
                     addr_cnt  <= '0;
                     last_addr <= shift[4:0] - 5'd1;
`ifdef LOADER_CHECKSUM_EN
                     sum       <= '0;
`endif
                  end else begin
                     err     <= 1'b1;
                     p_state <= P_HUNT;
                  end
               end
               P_PAYLOAD: begin
                  load_we   <= 1'b1;
                  load_addr <= addr_cnt;
                  load_data <= shift;
                  addr_cnt  <= addr_cnt + 5'd1;
`ifdef LOADER_CHECKSUM_EN
                  sum       <= sum + shift;
                  if (addr_cnt == last_addr) p_state <= P_CHK;
`else
                  if (addr_cnt == last_addr) finish_pending <= 1'b1;
`endif
               end
`ifdef LOADER_CHECKSUM_EN
               P_CHK: begin
                  done    <= (chk_sum == 8'h00);
                  err     <= (chk_sum != 8'h00);
                  p_state <= P_HUNT;
               end
`endif
            endcase
         end
`ifndef LOADER_CHECKSUM_EN
         // Without a checksum the frame closes one cycle after the last write.
         else if (finish_pending) begin
            finish_pending <= 1'b0;
            done           <= 1'b1;
            p_state        <= P_HUNT;
         end
`endif
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: vector table, corner-case sequences, randomized frames.
module tb_program_loader;

   localparam int CPB   = 8;
   localparam int DEPTH = 27;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic       load_we;
   logic [4:0] load_addr;
   logic [7:0] load_data;
   logic       cpu_hold, busy, done, err;

   program_loader #(.CLKS_PER_BIT(CPB), .MEM_DEPTH(DEPTH), .SYNC_BYTE(8'h55)) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .load_we(load_we), .load_addr(load_addr),
      .load_data(load_data), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef logic [7:0] bq_t[$];
   typedef struct {logic [4:0] addr; logic [7:0] data; int cyc;} wr_t;
   typedef struct {
      logic [7:0] b [8];
      int nb; int pay_off; int exp_wr;
      int done_c; int err_c; int done_n; int err_n;
   } vec_t;

   int  n_checks = 0;
   int  n_err    = 0;
   int  cyc      = 0;
   wr_t wq[$];
   int  done_cnt = 0;
   int  done_cyc = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (load_we) begin
         wq.push_back('{addr: load_addr, data: load_data, cyc: cyc});
         check("hold_during_write", cpu_hold, 1);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         check("hold_low_at_done", cpu_hold, 0);
      end
   end

   task automatic clear_mon();
      wq.delete();
      done_cnt = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop);
      rxd = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         idle(CPB);
      end
      rxd = stop;
      idle(CPB);
      rxd = 1'b1;
      if (!stop) idle(2 * CPB);
   endtask

   task automatic send_frame(input bq_t bytes);
      foreach (bytes[i]) send_byte(bytes[i], 1'b1);
      idle(CPB);
   endtask

   task automatic check_writes(input string name, input bq_t exp);
      check({name, "_count"}, wq.size(), exp.size());
      for (int i = 0; i < wq.size() && i < exp.size(); i++) begin
         check({name, "_addr"}, wq[i].addr, i);
         check({name, "_data"}, wq[i].data, exp[i]);
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vt[6];
      bq_t  tx, exp;
      logic [7:0] n, sum, chk;
      logic saved_err;
      bit   valid, ok;

      vt[0] = '{b: '{8'h55,8'h03,8'h01,8'h05,8'h02,8'hF8,8'h00,8'h00}, nb: 6, pay_off: 2, exp_wr: 3,
                done_c: 1, err_c: 0, done_n: 1, err_n: 0};
      vt[1] = '{b: '{8'h55,8'h02,8'h01,8'h05,8'h00,8'h00,8'h00,8'h00}, nb: 5, pay_off: 2, exp_wr: 2,
                done_c: 0, err_c: 1, done_n: 1, err_n: 0};
      vt[2] = '{b: '{8'h55,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, nb: 2, pay_off: 0, exp_wr: 0,
                done_c: 0, err_c: 1, done_n: 0, err_n: 1};
      vt[3] = '{b: '{8'h55,8'h1C,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, nb: 2, pay_off: 0, exp_wr: 0,
                done_c: 0, err_c: 1, done_n: 0, err_n: 1};
      vt[4] = '{b: '{8'hAA,8'h13,8'h55,8'h01,8'h0A,8'hF6,8'h00,8'h00}, nb: 6, pay_off: 4, exp_wr: 1,
                done_c: 1, err_c: 0, done_n: 1, err_n: 0};
      vt[5] = '{b: '{8'h55,8'h01,8'hFF,8'h01,8'h00,8'h00,8'h00,8'h00}, nb: 4, pay_off: 2, exp_wr: 1,
                done_c: 1, err_c: 0, done_n: 1, err_n: 0};

      // Reset state
      rst = 1'b1;
      rxd = 1'b1;
      idle(3);
      check("rst_load_we", load_we, 0);
      check("rst_load_addr", load_addr, 0);
      check("rst_load_data", load_data, 0);
      check("rst_cpu_hold", cpu_hold, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      rst = 1'b0;
      idle(4);

      // Vector table
      for (int v = 0; v < 6; v++) begin
         clear_mon();
         tx.delete();
         exp.delete();
         for (int i = 0; i < vt[v].nb; i++) tx.push_back(vt[v].b[i]);
         for (int i = 0; i < vt[v].exp_wr; i++) exp.push_back(vt[v].b[vt[v].pay_off + i]);
         send_frame(tx);
         check_writes($sformatf("vec%0d_wr", v), exp);
         check($sformatf("vec%0d_done", v), done_cnt, CHK_EN ? vt[v].done_c : vt[v].done_n);
         check($sformatf("vec%0d_err", v), err, CHK_EN ? vt[v].err_c : vt[v].err_n);
         check($sformatf("vec%0d_busy", v), busy, 0);
         check($sformatf("vec%0d_hold", v), cpu_hold, 0);
         if (v == 0 && wq.size() == 3) begin
            check("byte_spacing", wq[1].cyc - wq[0].cyc, 10 * CPB);
            check("done_latency", done_cyc - wq[2].cyc, CHK_EN ? 10 * CPB : 1);
         end
      end

      // Error flag cleared by the next accepted SYNC, hold asserted from SYNC acceptance
      clear_mon();
      send_frame('{8'h55, 8'h02, 8'h01, 8'h05, 8'h00});
      check("badchk_err", err, CHK_EN ? 1 : 0);
      send_frame('{8'h55});
      check("sync_clears_err", err, 0);
      check("sync_hold", cpu_hold, 1);
      check("sync_busy", busy, 1);
      send_frame('{8'h00});
      check("len0_err", err, 1);
      check("len0_busy", busy, 0);

      // Quarter-bit low glitch on idle line
      clear_mon();
      saved_err = err;
      rxd = 1'b0;
      idle(CPB / 4);
      rxd = 1'b1;
      idle(3 * CPB);
      check("glitch_writes", wq.size(), 0);
      check("glitch_busy", busy, 0);
      check("glitch_err", err, saved_err);
      check("glitch_done", done_cnt, 0);

      // Framing error mid-payload
      clear_mon();
      send_frame('{8'h55, 8'h04, 8'h11, 8'h22});
      send_byte(8'h33, 1'b0);
      check("frame_err_err", err, 1);
      check("frame_err_busy", busy, 0);
      check("frame_err_hold", cpu_hold, 0);
      send_frame('{8'h44});
      check_writes("frame_err_wr", '{8'h11, 8'h22});
      check("frame_err_done", done_cnt, 0);

      // Reset mid-frame, then a clean frame loads from address 0
      clear_mon();
      send_frame('{8'h55, 8'h05, 8'hA1, 8'hA2});
      rst = 1'b1;
      idle(1);
      check("mid_rst_load_we", load_we, 0);
      check("mid_rst_addr", load_addr, 0);
      check("mid_rst_data", load_data, 0);
      check("mid_rst_hold", cpu_hold, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_err", err, 0);
      rst = 1'b0;
      idle(2);
      check_writes("pre_rst_wr", '{8'hA1, 8'hA2});
      check("pre_rst_done", done_cnt, 0);
      clear_mon();
      tx = '{8'h55, 8'h02, 8'h33, 8'h44};
      if (CHK_EN) tx.push_back(8'h89);
      send_frame(tx);
      check_writes("post_rst_wr", '{8'h33, 8'h44});
      check("post_rst_done", done_cnt, 1);
      check("post_rst_err", err, 0);

      // Randomized frames against a frame-level reference model
      for (int f = 0; f < 12; f++) begin
         int kind, junk;
         clear_mon();
         tx.delete();
         exp.delete();
         junk = $urandom_range(0, 2);
         for (int j = 0; j < junk; j++) begin
            logic [7:0] jb;
            jb = 8'($urandom_range(0, 255));
            if (jb == 8'h55) jb = 8'h54;
            tx.push_back(jb);
         end
         kind = $urandom_range(0, 9);
         if (f == 0)         n = 8'(DEPTH);
         else if (kind == 0) n = 8'd0;
         else if (kind == 1) n = 8'($urandom_range(DEPTH + 1, 255));
         else                n = 8'($urandom_range(1, DEPTH));
         valid = (n >= 1) && (n <= DEPTH);
         ok    = ($urandom_range(0, 3) != 0);
         tx.push_back(8'h55);
         tx.push_back(n);
         sum = 8'h00;
         if (valid) begin
            for (int i = 0; i < n; i++) begin
               logic [7:0] pb;
               pb = 8'($urandom_range(0, 255));
               exp.push_back(pb);
               tx.push_back(pb);
               sum = sum + pb;
            end
            chk = 8'h00 - sum;
            if (!ok) chk = chk ^ 8'($urandom_range(1, 255));
            if (CHK_EN) tx.push_back(chk);
         end
         send_frame(tx);
         check_writes($sformatf("rnd%0d_wr", f), exp);
         check($sformatf("rnd%0d_done", f), done_cnt, (valid && (!CHK_EN || ok)) ? 1 : 0);
         check($sformatf("rnd%0d_err", f), err, (!valid || (CHK_EN && !ok)) ? 1 : 0);
         check($sformatf("rnd%0d_hold", f), cpu_hold, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
